// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared constants and types for the async-FIFO read-side stream logic.
//   FIFO_DATA_WIDTH : default word width
//   occ_t           : buffered word count (0..2)
//   OCC_MAX         : depth of the output skid buffer
package fifo_pkg;
    localparam int FIFO_DATA_WIDTH = 8;
    typedef logic [1:0] occ_t;
    localparam occ_t OCC_MAX = 2'd2;
endpackage

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf
//   Two-entry circular buffer that absorbs the FIFO's one-cycle read latency.
//   Ports:
//     i_clk, i_rst_n : clock, async active-low reset
//     i_clr          : synchronous clear of pointers and count (stored data kept)
//     i_wr, i_wdata  : write strobe and word, stored at the tail
//     i_rd           : read strobe, advances the head
//     o_occ          : number of stored words
//     o_rdata        : word at the head
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clr,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_rd,
    output occ_t                  o_occ,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:1];
    logic                  r_head;
    logic                  r_tail;
    occ_t                  r_occ;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_head <= 1'b0;
            r_tail <= 1'b0;
            r_occ  <= '0;
        end else if (i_clr) begin
            // Clear wins over a coincident write or read: the word is dropped.
            r_head <= 1'b0;
            r_tail <= 1'b0;
            r_occ  <= '0;
        end else begin
            if (i_wr) begin
                r_mem[r_tail] <= i_wdata;
                r_tail        <= ~r_tail;
            end
            if (i_rd) begin
                r_head <= ~r_head;
            end
            case ({i_wr, i_rd})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_occ   = r_occ;
    assign o_rdata = r_mem[r_head];

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Read-side drain engine for the async FIFO (read clock domain). Fetches
//   words from the FIFO and presents them as a valid/ready stream, using a
//   two-entry skid buffer to hide the FIFO's one-cycle read latency so that
//   one word per cycle is sustained.
//   Optional feature macro: FIFO_RD_STATS_EN adds a saturating transfer
//   counter on o_xfer_count (cleared only by reset).
//   Ports:
//     i_clk, i_rst_n   : read clock, async active-low reset
//     i_enable         : permit new FIFO reads (buffered words drain regardless)
//     i_flush          : one-cycle pulse, discards buffered and in-flight words
//     i_fifo_empty     : FIFO empty flag
//     i_fifo_data      : FIFO read data, valid the cycle after o_fifo_rd_en
//     o_fifo_rd_en     : FIFO read strobe
//     o_m_valid, i_m_ready, o_m_data : output stream
//     o_occupancy      : buffered word count (0..2)
//     o_xfer_count     : completed transfers (FIFO_RD_STATS_EN only)
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic                  i_flush,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    output logic                  o_fifo_rd_en,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic [DATA_WIDTH-1:0] o_m_data,
    output occ_t                  o_occupancy
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  o_xfer_count
`endif
);

    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("CNT_WIDTH must be at least 1");
    end

    logic       r_infl;
    logic       r_drop;
    occ_t       w_occ;
    logic       w_pop;
    logic       w_capture;
    logic       w_rd_en;
    logic [2:0] w_sum;

    assign w_pop = o_m_valid & i_m_ready;
    assign w_sum = {1'b0, w_occ} + {2'b00, r_infl};

    // A new read may be issued only if the word it returns is guaranteed a
    // slot: either a slot is free now, or the buffer is full-with-pending but
    // a word leaves this cycle.
    assign w_rd_en = i_enable & ~i_fifo_empty & ~i_flush &
                     ((w_sum < 3'(OCC_MAX)) | ((w_sum == 3'(OCC_MAX)) & w_pop));

    // r_drop covers a return arriving the cycle after a flush.
    assign w_capture = r_infl & ~i_flush & ~r_drop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_infl <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            r_infl <= w_rd_en;
            r_drop <= i_flush;
        end
    end

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_flush),
        .i_wr    (w_capture),
        .i_wdata (i_fifo_data),
        .i_rd    (w_pop),
        .o_occ   (w_occ),
        .o_rdata (o_m_data)
    );

    assign o_fifo_rd_en = w_rd_en;
    assign o_m_valid    = (w_occ != '0);
    assign o_occupancy  = w_occ;

`ifdef FIFO_RD_STATS_EN
    logic [CNT_WIDTH-1:0] r_xfer;

    // Saturating; a flush does not clear it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_xfer <= '0;
        end else if (w_pop && (r_xfer != '1)) begin
            r_xfer <= r_xfer + CNT_WIDTH'(1);
        end
    end

    assign o_xfer_count = r_xfer;
`endif

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                    w_sum <= 3'(OCC_MAX));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream
//   Self-checking bench for fifo_rd_stream. A behavioural FIFO feeds the DUT;
//   a queue-based reference model predicts read strobes and stream output.
//   Define FIFO_RD_STATS_EN to also exercise the transfer counter (CNT_WIDTH=4).
module tb_fifo_rd_stream;

    localparam int CNTW = 4;
    localparam int CNT_MAX = (1 << CNTW) - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       flush;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd_en;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [1:0] occupancy;
`ifdef FIFO_RD_STATS_EN
    logic [CNTW-1:0] xfer_count;
`endif

    always #5 clk = ~clk;

    fifo_rd_stream #(
        .DATA_WIDTH (8)
`ifdef FIFO_RD_STATS_EN
        ,
        .CNT_WIDTH  (CNTW)
`endif
    ) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (enable),
        .i_flush      (flush),
        .i_fifo_empty (fifo_empty),
        .i_fifo_data  (fifo_data),
        .o_fifo_rd_en (fifo_rd_en),
        .o_m_valid    (m_valid),
        .i_m_ready    (m_ready),
        .o_m_data     (m_data),
        .o_occupancy  (occupancy)
`ifdef FIFO_RD_STATS_EN
        ,
        .o_xfer_count (xfer_count)
`endif
    );

    // Behavioural source FIFO with one-cycle read latency.
    int fifo_mem [4096];
    int fifo_wp = 0;
    int fifo_rp = 0;
    assign fifo_empty = (fifo_wp == fifo_rp);

    always @(posedge clk) begin
        if (fifo_rd_en && (fifo_rp != fifo_wp)) begin
            fifo_data <= 8'(fifo_mem[fifo_rp % 4096]);
            fifo_rp   <= fifo_rp + 1;
        end
    end

    task automatic push(input int v);
        fifo_mem[fifo_wp % 4096] = v;
        fifo_wp++;
    endtask

    // Reference model state
    int  m_buf[$];
    int  deliv_q[$];
    bit  m_infl;
    bit  m_drop;
    int  m_infl_word;
    int  n_deliv;
    int  n_rd;
    int  m_xfer;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_buf.delete();
        deliv_q.delete();
        m_infl = 0;
        m_drop = 0;
        m_infl_word = 0;
        n_deliv = 0;
        n_rd = 0;
        m_xfer = 0;
    endtask

    // Called at the negedge: compare, then advance the model to the next cycle.
    task automatic model_step();
        int  e_occ;
        bit  e_valid;
        bit  pop;
        bit  e_rd;
        int  sum;
        e_occ   = m_buf.size();
        e_valid = (e_occ != 0);
        pop     = e_valid && m_ready;
        sum     = e_occ + int'(m_infl);
        e_rd    = enable && !fifo_empty && !flush &&
                  ((sum < 2) || (sum == 2 && pop));
        check("rd_en", 32'(fifo_rd_en), 32'(e_rd));
        check("m_valid", 32'(m_valid), 32'(e_valid));
        check("occupancy", 32'(occupancy), 32'(e_occ));
        if (e_valid) check("m_data", 32'(m_data), 32'(m_buf[0]));
`ifdef FIFO_RD_STATS_EN
        check("xfer_count", 32'(xfer_count), 32'(m_xfer));
`endif
        if (sum > 2) check("occ_plus_infl", 32'(sum), 32'd2);
        if (fifo_rd_en) n_rd++;
        if (pop) begin
            deliv_q.push_back(m_buf.pop_front());
            n_deliv++;
            if (m_xfer < CNT_MAX) m_xfer++;
        end
        if (flush) m_buf.delete();
        else if (m_infl && !m_drop) m_buf.push_back(m_infl_word);
        m_drop = flush;
        m_infl = e_rd;
        if (e_rd) m_infl_word = fifo_mem[fifo_rp % 4096];
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable  = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        rst_n   = 1'b0;
        #1;
        fifo_wp = fifo_rp;
        model_clear();
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
`ifdef FIFO_RD_STATS_EN
        check("rst_xfer_count", 32'(xfer_count), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       rdy;
        logic       e_rd;
        logic       e_valid;
        logic [7:0] e_data;
        logic [1:0] e_occ;
    } vec_t;

    vec_t tv[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int rd_before;
        tv[0] = '{1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
        tv[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
        tv[2] = '{1'b1, 1'b1, 1'b1, 8'hA1, 2'd1};
        tv[3] = '{1'b1, 1'b0, 1'b1, 8'hB2, 2'd1};
        tv[4] = '{1'b1, 1'b0, 1'b1, 8'hC3, 2'd1};
        tv[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 2'd0};

        // 1: three words, downstream always ready
        do_reset();
        push(8'hA1); push(8'hB2); push(8'hC3);
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            m_ready = tv[i].rdy;
            @(negedge clk);
            check($sformatf("t1_rd_%0d", i), 32'(fifo_rd_en), 32'(tv[i].e_rd));
            check($sformatf("t1_valid_%0d", i), 32'(m_valid), 32'(tv[i].e_valid));
            check($sformatf("t1_occ_%0d", i), 32'(occupancy), 32'(tv[i].e_occ));
            if (tv[i].e_valid) check($sformatf("t1_data_%0d", i), 32'(m_data), 32'(tv[i].e_data));
            model_step();
            @(posedge clk);
            #1;
        end
        check("t1_delivered", 32'(n_deliv), 32'd3);

        // 2: back-pressure with five words
        do_reset();
        for (int i = 0; i < 5; i++) push(8'h10 + i);
        enable = 1'b1;
        repeat (6) tick();
        check("t2_rd_pulses", 32'(n_rd), 32'd2);
        check("t2_occ_full", 32'(occupancy), 32'd2);
        check("t2_head_stable", 32'(m_data), 32'h10);
        m_ready = 1'b1;
        cyc = 0;
        while (n_deliv < 5 && cyc < 20) begin tick(); cyc++; end
        check("t2_delivered", 32'(n_deliv), 32'd5);
        check("t2_drain_cycles", 32'(cyc), 32'd5);
        check("t2_order_last", 32'(deliv_q[deliv_q.size()-1]), 32'h14);

        // 3: m_ready toggling over eight words
        do_reset();
        for (int i = 0; i < 8; i++) push(8'h30 + i);
        enable = 1'b1;
        cyc = 0;
        while (n_deliv < 8 && cyc < 40) begin m_ready = cyc[0]; tick(); cyc++; end
        check("t3_delivered", 32'(n_deliv), 32'd8);
        check("t3_order_first", 32'(deliv_q[0]), 32'h30);

        // 4: flush with one buffered and one in flight
        do_reset();
        for (int i = 0; i < 6; i++) push(8'h60 + i);
        enable = 1'b1;
        repeat (2) tick();
        check("t4_pre_occ", 32'(occupancy), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_post_valid", 32'(m_valid), 32'd0);
        check("t4_post_occ", 32'(occupancy), 32'd0);
        m_ready = 1'b1;
        cyc = 0;
        while (n_deliv < 4 && cyc < 20) begin tick(); cyc++; end
        check("t4_delivered", 32'(n_deliv), 32'd4);
        check("t4_first_after_flush", 32'(deliv_q[0]), 32'h62);
        repeat (3) tick();
        check("t4_no_extra", 32'(n_deliv), 32'd4);

        // 5: enable low drains but does not fetch
        do_reset();
        push(8'h70);
        enable = 1'b1;
        repeat (3) tick();
        push(8'h71); push(8'h72); push(8'h73);
        enable = 1'b0;
        m_ready = 1'b1;
        rd_before = n_rd;
        repeat (3) tick();
        check("t5_drained_occ", 32'(occupancy), 32'd0);
        check("t5_no_fetch", 32'(n_rd - rd_before), 32'd0);
        enable = 1'b1;
        @(negedge clk);
        check("t5_resume_rd", 32'(fifo_rd_en), 32'd1);
        model_step();
        @(posedge clk);
        #1;
        cyc = 0;
        while (n_deliv < 4 && cyc < 20) begin tick(); cyc++; end
        check("t5_delivered", 32'(n_deliv), 32'd4);
        check("t5_order_last", 32'(deliv_q[3]), 32'h73);

        // 6: randomized traffic with a mid-stream reset
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (c == 200) do_reset();
            if ((fifo_wp - fifo_rp) < 20 && $urandom_range(0, 9) < 4) push(int'($urandom_range(0, 255)));
            enable  = ($urandom_range(0, 7) != 0);
            flush   = ($urandom_range(0, 19) == 0);
            m_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        flush = 1'b0;

`ifdef FIFO_RD_STATS_EN
        // 7: transfer counter saturation
        do_reset();
        for (int i = 0; i < 20; i++) push(i);
        enable  = 1'b1;
        m_ready = 1'b1;
        cyc = 0;
        while (n_deliv < 20 && cyc < 60) begin tick(); cyc++; end
        check("t7_delivered", 32'(n_deliv), 32'd20);
        check("t7_saturated", 32'(xfer_count), 32'd15);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t7_flush_keeps", 32'(xfer_count), 32'd15);
        do_reset();
        check("t7_reset_clears", 32'(xfer_count), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
